// File: rtl/wb_scheduler.sv
// Writeback scheduler: per-register pending-write scoreboard plus a single-port
// ALU/LSU writeback arbiter. Define WB_RR_EN for round-robin arbitration (default: LSU priority).
module wb_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [4:0]  iss_ra,
    input  logic [4:0]  iss_rb,
    input  logic [4:0]  iss_rd,
    output logic        iss_stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic        regwrite,
    output logic [4:0]  rd,
    output logic [31:0] writedata,
    output logic [31:0] busy
);

    logic [31:0] busy_q, busy_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] writedata_q, writedata_d;
    logic        prefer_lsu;
    logic        issue_go;

`ifdef WB_RR_EN
    // Pointer remembers the last winner; 0 means ALU was granted last.
    logic last_lsu_q, last_lsu_d;

    always_comb begin
        prefer_lsu = !last_lsu_q;
        last_lsu_d = last_lsu_q;
        if (lsu_ready) begin
            last_lsu_d = 1'b1;
        end else if (alu_ready) begin
            last_lsu_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b0;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`else
    always_comb begin
        prefer_lsu = 1'b1;
    end
`endif

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            if (lsu_valid && (!alu_valid || prefer_lsu)) begin
                lsu_ready = 1'b1;
            end else if (alu_valid) begin
                alu_ready = 1'b1;
            end
        end
    end

    // Stalling on busy[iss_rd] as well as the sources keeps at most one write in flight per register.
    always_comb begin
        iss_stall = !rst && iss_valid &&
                    (busy_q[iss_ra] || busy_q[iss_rb] || busy_q[iss_rd]);
        issue_go  = iss_valid && !iss_stall && (iss_rd != 5'd0);
    end

    always_comb begin
        busy_d      = busy_q;
        regwrite_d  = 1'b0;
        rd_d        = rd_q;
        writedata_d = writedata_q;
        if (regwrite_q) begin
            busy_d[rd_q] = 1'b0;
        end
        // Set is applied after clear so a same-index reservation wins.
        if (issue_go) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (lsu_ready) begin
            rd_d        = lsu_rd;
            writedata_d = lsu_data;
            regwrite_d  = (lsu_rd != 5'd0);
        end else if (alu_ready) begin
            rd_d        = alu_rd;
            writedata_d = alu_data;
            regwrite_d  = (alu_rd != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 32'd0;
            regwrite_q  <= 1'b0;
            rd_q        <= 5'd0;
            writedata_q <= 32'd0;
        end else begin
            busy_q      <= busy_d;
            regwrite_q  <= regwrite_d;
            rd_q        <= rd_d;
            writedata_q <= writedata_d;
        end
    end

    assign regwrite  = regwrite_q;
    assign rd        = rd_q;
    assign writedata = writedata_q;
    assign busy      = busy_q;

endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst in 1, reset.
REQ-002 SHALL have issue ports: iss_valid in 1; iss_ra in 5; iss_rb in 5; iss_rd in 5; iss_stall out 1, combinational hazard flag.
REQ-003 SHALL have ALU writeback ports: alu_valid in 1; alu_rd in 5; alu_data in 32; alu_ready out 1, combinational grant.
REQ-004 SHALL have LSU writeback ports: lsu_valid in 1; lsu_rd in 5; lsu_data in 32; lsu_ready out 1, combinational grant.
REQ-005 SHALL have register-file write port outputs, all registered: regwrite out 1; rd out 5; writedata out 32.
REQ-006 SHALL have busy out 32, the registered per-register pending-write scoreboard, with bit 0 always 0.
REQ-007 SHALL use one clock, clk, and a synchronous active-high reset, rst.

Function
REQ-008 SHALL drive iss_stall = iss_valid && (busy[iss_ra] || busy[iss_rb] || busy[iss_rd]), covering RAW and WAW hazards.
REQ-009 SHALL set busy[iss_rd] at the clock edge when iss_valid && !iss_stall && iss_rd != 0 (reservation).
REQ-010 SHALL clear busy[rd] at the clock edge ending any cycle with regwrite=1, so a dependent read issues only after the register file holds the new value.
REQ-011 SHALL let set win if a set and a clear of the same index occur together; per REQ-008 this cannot occur with legal stimulus.
REQ-012 SHALL grant at most one requester per cycle; alu_ready/lsu_ready high only with the matching valid; the write stage accepts every cycle, so there is no back-pressure beyond arbitration.
REQ-013 SHALL, on a grant, load rd/writedata from the winner at the next edge, with regwrite=1 iff winner rd != 0.
REQ-014 SHALL accept an rd=0 request (ready=1) but write nothing, leaving regwrite=0.
REQ-015 SHALL hold regwrite=0 for the next cycle when nothing is granted; rd/writedata hold their previous values.
REQ-016 SHALL have latency grant edge E0 -> regwrite visible in cycle E0..E1 -> register written and busy cleared at E1.
REQ-017 SHALL, for a request whose rd is not busy, write it normally (no checking).
REQ-018 SHALL write nothing to busy on an iss_rd=0 reservation.

Reset
REQ-019 SHALL, while rst=1 at an edge, set busy=0, regwrite=0, rd=0, writedata=0 and the round-robin pointer to "ALU last".
REQ-020 SHALL keep alu_ready=lsu_ready=0 and iss_stall=0 combinationally while rst=1.
REQ-021 SHALL, on reset mid-operation, drop any in-flight granted write (regwrite=0 after the edge) and abandon all reservations.

Configuration
REQ-022 SHALL use macro WB_RR_EN.
REQ-023 SHALL, with WB_RR_EN defined, arbitrate round-robin: on contention grant the requester not granted last; the pointer updates on every grant to the winner.
REQ-024 SHALL, without WB_RR_EN, use fixed priority LSU over ALU, with no pointer register present.
REQ-025 SHALL treat single-requester cycles identically in both builds.

Verification
REQ-026 Reset then issue iss_rd=5 -> busy=0x00000020 next cycle; issue ra=5 -> iss_stall=1.
REQ-027 ALU alu_rd=5, data 0xDEADBEEF -> alu_ready=1; next cycle regwrite=1, rd=5, writedata=0xDEADBEEF; the following cycle busy[5]=0 and ra=5 issue has iss_stall=0.
REQ-028 ALU and LSU both valid for 4 cycles, rd=3/4, with WB_RR_EN -> grants L,A,L,A; without it -> L,L,L,L.
REQ-029 lsu_rd=0, data 0x1234 -> lsu_ready=1; regwrite stays 0; busy unchanged.
REQ-030 Grant alu_rd=7 with busy[7]=1, rst=1 the next edge -> regwrite=0, busy=0 after that edge.
REQ-031 Issue iss_rd=9 while busy[9]=1 -> iss_stall=1, busy unchanged; after the write clears it -> reservation succeeds.
